data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
- Two-requester arbiter and sub-word access controller in front of the 32x32 data RAM (synchronous byte-enabled write, asynchronous read).
- m0 is the CPU load/store port; m1 is the debug/program-loader port.
- The block arbitrates per cycle using round-robin with a bounded lock for m1 bursts.
- It converts byte/half/word requests into RAM byte-enables and replicated write data, aligns and extends load data, and returns a registered response one cycle after grant.

Parameters:
- LOCK_MAX, 8: maximum consecutive locked grants to m1 while m0 is requesting before m0 is forced in (range 1..255).
- AW, 7: byte address width. Word index is addr[AW-1:2], giving 32 words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  request valid (N=0,1); held with all fields until mN_gnt.
- mN_we  in  1  1 = store, 0 = load.
- mN_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mN_sext  in  1  load sign-extend (byte/half only).
- mN_addr  in  AW  byte address.
- mN_wdata  in  32  store data, right-aligned.
- mN_gnt  out  1  combinational; request accepted this cycle.
- mN_rvalid  out  1  registered; response for the request granted in the previous cycle.
- mN_rdata  out  32  registered load data (0 for stores and errors).
- mN_err  out  1  registered; valid with mN_rvalid.
- m1_lock  in  1  keep the grant on m1 for the following cycles.
- ram_wen  out  4  byte write enables to RAM.
- ram_addr  out  5  word address to RAM.
- ram_wdata  out  32  lane-replicated write data.
- ram_rdata  in  32  asynchronous RAM read data.

Behaviour:
- Reset (rst high at a clk edge):
  - mN_rvalid=0, mN_err=0, mN_rdata=0.
  - Round-robin pointer last=1, so m0 wins first.
  - Lock counter lcnt=0, locked=0.
- Grant is combinational each cycle. At most one of m0_gnt/m1_gnt is high, and never while rst=1.
  - Only one master requesting: that master is granted.
  - Both requesting, locked=0: grant the master not equal to last.
  - Both requesting, locked=1 and lcnt<LOCK_MAX: grant m1.
  - Both requesting, locked=1 and lcnt==LOCK_MAX: grant m0.
- Lock state, updated at each edge:
  - locked <= m1_gnt & m1_lock.
  - lcnt increments on each m1_gnt while locked and m0_req.
  - lcnt clears on m0_gnt, on any edge where m0_req=0, or when m1_lock=0.
  - last <= granted master; unchanged when idle.
- RAM side is driven from the granted request in the same cycle:
  - ram_addr = addr[6:2]; off = addr[1:0].
  - ram_wen = 0 when there is no grant, a load, or an error.
  - Byte store: ram_wen = 4'b0001<<off; ram_wdata = {4{wdata[7:0]}}.
  - Half store: ram_wen = 4'b0011<<off; ram_wdata = {2{wdata[15:0]}}.
  - Word store: ram_wen = 4'b1111; ram_wdata = wdata.
  - Little-endian: lane k = bits[8k+7:8k].
  - With no grant, ram_addr and ram_wdata are don't-care but must not be X (drive 0).
- Error conditions: size=11, half with off[0]=1, or word with off!=0.
  - The request is still granted (consumed).
  - No RAM write occurs.
  - Next cycle: rvalid=1, err=1, rdata=0.
- Load path: at the granting edge, the selected lane(s) of ram_rdata are captured and zero- or sign-extended per sext.
  - Word loads ignore sext.
  - Load data is valid on mN_rdata with mN_rvalid in cycle N+1.
- Stores: write commits at the end of the grant cycle; rvalid pulses next cycle with rdata=0.
- Latency is exactly 1 cycle from grant to rvalid.
  - Back-to-back grants to the same or alternating masters are allowed, giving 1 access per cycle.
  - rvalid goes only to the master granted in the previous cycle.
- Read-after-write in consecutive cycles returns the new data, because the RAM write lands before the next cycle's asynchronous read.
- Reset asserted mid-stream: outstanding responses are dropped (rvalid=0 next cycle); a write granted in the same cycle as rst does not occur.
- No response backpressure: masters must accept rvalid.

Decomposition:
- Package data_ram_pkg holds:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_RSV encodings.
  - Width constants: AW, word-address width 5, data width 32.
  - Master index constants M0/M1.
- One combinational sub-module, mem_lane_align, computes:
  - ram_wen, ram_wdata, err from (we, size, off, wdata).
  - Extracted/extended load data from (size, sext, off, ram_rdata).

Test Plan:
- After reset, m0 stores word 0x11223344 to addr 0x08, then loads it. Expect ram_wen=1111, ram_addr=2, and on the load m0_rvalid with m0_rdata=0x11223344, err=0.
- m1 stores byte 0x80 to addr 0x09, then m0 loads the byte with sext=1 and sext=0 from 0x09. Expect ram_wen=0010; rdata=0xFFFFFF80 and 0x00000080; word 2 reads 0x11228044.
- Both masters request continuously without lock. Expect grants alternating m0,m1,m0,m1, and rvalid each to the matching master one cycle later.
- m1_lock=1 with both requesting and LOCK_MAX=8. Expect 8 consecutive m1 grants, then one m0 grant, then lock resumes.
- m0 half load at addr 0x03 and word store at addr 0x06. Expect gnt=1, ram_wen=0, next cycle err=1, rdata=0; RAM contents unchanged.
- rst asserted in the cycle of an m1 word store. Expect no write, no rvalid next cycle, m0 granted first after reset.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared encodings and widths for the data RAM arbiter
package data_ram_pkg;
  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;
  localparam int AW = 7;
  localparam int WAW = 5;
  localparam int DW = 32;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: one requester's access and response bundle
interface data_ram_arbiter_if #(parameter int AW = 7);
  logic req;
  logic we;
  logic [1:0] size;
  logic sext;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  logic err;
  modport master (output req, we, size, sext, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave (input req, we, size, sext, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, write replication and load extraction
module mem_lane_align
  import data_ram_pkg::*;
(
  input  logic          we,
  input  logic [1:0]    size,
  input  logic [1:0]    off,
  input  logic [DW-1:0] wdata,
  input  logic          sext,
  input  logic [DW-1:0] rdata,
  output logic [3:0]    wen,
  output logic [DW-1:0] wdata_o,
  output logic          err,
  output logic [DW-1:0] ldata
);
  logic [15:0] sh;
  // misaligned or reserved accesses never write; loads take the addressed lanes
  always_comb begin
    err = size == SIZE_RSV || (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
    wen = (!we || err) ? 4'b0000 : size == SIZE_B ? 4'b0001 << off : size == SIZE_H ? 4'b0011 << off : 4'b1111;
    wdata_o = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
    sh = 16'(rdata >> {off, 3'b000});
    ldata = size == SIZE_B ? {{24{sext & sh[7]}}, sh[7:0]} : size == SIZE_H ? {{16{sext & sh[15]}}, sh} : rdata;
  end
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-port round-robin arbiter with m1 burst lock in front of the data RAM
module data_ram_arbiter
  import data_ram_pkg::*;
#(
  parameter int LOCK_MAX = 8,
  parameter int AW = data_ram_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_arbiter_if.slave m0,
  data_ram_arbiter_if.slave m1,
  input  logic             m1_lock,
  output logic [3:0]       ram_wen,
  output logic [WAW-1:0]   ram_addr,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata
);
  localparam logic [7:0] LMAX = 8'(LOCK_MAX);
  logic last, locked, sel1, g0, g1, we, sext, err;
  logic rv0, rv1, e0, e1;
  logic [1:0] size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, ldata, rsp, rd0, rd1;
  logic [7:0] lcnt;
  // pick m1 on contention when locked under budget, otherwise round-robin
  always_comb begin
    sel1 = (m0.req & m1.req) ? (locked ? lcnt < LMAX : !last) : m1.req;
    g0 = !rst & m0.req & !sel1;
    g1 = !rst & m1.req & sel1;
  end
  // steer the granted request to the RAM; zeros when idle keep the bus defined
  always_comb begin
    we = g1 ? m1.we : g0 & m0.we;
    sext = g1 ? m1.sext : g0 & m0.sext;
    size = g1 ? m1.size : g0 ? m0.size : SIZE_B;
    addr = g1 ? m1.addr : g0 ? m0.addr : '0;
    wdata = g1 ? m1.wdata : g0 ? m0.wdata : '0;
  end
  mem_lane_align u_align (
    .we(we), .size(size), .off(addr[1:0]), .wdata(wdata), .sext(sext), .rdata(ram_rdata),
    .wen(ram_wen), .wdata_o(ram_wdata), .err(err), .ldata(ldata)
  );
  assign ram_addr = addr[AW-1:2];
  assign rsp = (we | err) ? '0 : ldata;
  // arbitration history, lock budget and one-cycle registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= M1;
      locked <= 1'b0;
      lcnt <= '0;
      {rv0, rv1, e0, e1} <= '0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      locked <= g1 & m1_lock;
      if (g0 | g1) last <= g1;
      lcnt <= (g0 | !m0.req | !m1_lock) ? '0 : g1 ? lcnt + 8'd1 : lcnt;
      rv0 <= g0;
      rv1 <= g1;
      e0 <= g0 & err;
      e1 <= g1 & err;
      rd0 <= g0 ? rsp : '0;
      rd1 <= g1 ? rsp : '0;
    end
  end
  assign m0.gnt = g0;
  assign m1.gnt = g1;
  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.err = e0;
  assign m1.err = e1;
  assign m0.rdata = rd0;
  assign m1.rdata = rd1;
endmodule
